// File: rtl/slc3_pkg.sv
// SLC-3 control definitions shared by the ISDU: state encoding, opcodes and
// datapath mux select encodings.
package slc3_pkg;

  typedef enum logic [4:0] {
    StHalted,
    StFetch1,
    StFetch2,
    StFetch3,
    StDecode,
    StAdd,
    StAnd,
    StNot,
    StBr,
    StBrT,
    StJmp,
    StJsr,
    StJsr2,
    StLdr1,
    StLdr2,
    StLdr3,
    StStr1,
    StStr2,
    StStr3,
    StPause1,
    StPause2
  } state_t;

  // Opcodes (IR[15:12])
  localparam logic [3:0] OP_BR    = 4'b0000;
  localparam logic [3:0] OP_ADD   = 4'b0001;
  localparam logic [3:0] OP_JSR   = 4'b0100;
  localparam logic [3:0] OP_AND   = 4'b0101;
  localparam logic [3:0] OP_LDR   = 4'b0110;
  localparam logic [3:0] OP_STR   = 4'b0111;
  localparam logic [3:0] OP_NOT   = 4'b1001;
  localparam logic [3:0] OP_JMP   = 4'b1100;
  localparam logic [3:0] OP_PAUSE = 4'b1101;

  // PCMUX
  localparam logic [1:0] PC_PLUS1 = 2'b00;
  localparam logic [1:0] PC_BUS   = 2'b01;
  localparam logic [1:0] PC_ADDER = 2'b10;

  // ADDR2MUX
  localparam logic [1:0] A2_ZERO  = 2'b00;
  localparam logic [1:0] A2_OFF6  = 2'b01;
  localparam logic [1:0] A2_OFF9  = 2'b10;
  localparam logic [1:0] A2_OFF11 = 2'b11;

  // ALUK
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_AND   = 2'b01;
  localparam logic [1:0] ALU_NOT   = 2'b10;
  localparam logic [1:0] ALU_PASSA = 2'b11;

endpackage

// File: rtl/isdu.sv
// SLC-3 Instruction Sequence Decode Unit: Moore control FSM that sequences
// fetch, decode and execute, including memory wait states of MEM_WAIT cycles.
// Optional feature macro: PAUSE_EN (opcode 1101 pauses with a Continue
// handshake and loads the LEDs; otherwise 1101 is a no-op).
module isdu
  import slc3_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 3
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run,
  input  logic       Continue,
  input  logic [3:0] Opcode,
  input  logic       IR_5,
  input  logic       BEN,
  output logic       LD_MAR,
  output logic       LD_MDR,
  output logic       LD_IR,
  output logic       LD_BEN,
  output logic       LD_CC,
  output logic       LD_REG,
  output logic       LD_PC,
  output logic       LD_LED,
  output logic       GatePC,
  output logic       GateMDR,
  output logic       GateALU,
  output logic       GateMARMUX,
  output logic [1:0] PCMUX,
  output logic [1:0] ADDR2MUX,
  output logic [1:0] ALUK,
  output logic       DRMUX,
  output logic       SR1MUX,
  output logic       SR2MUX,
  output logic       ADDR1MUX,
  output logic       MARMUX,
  output logic       Mem_OE,
  output logic       Mem_WE,
  output logic       MIO_EN
);

  // Counter value on the final cycle of a memory access
  localparam logic [2:0] WaitLast = 3'(MEM_WAIT - 1);

  state_t     state_q, state_d;
  logic [2:0] wait_q, wait_d;

  // State and wait counter registers
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= StHalted;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Immediate/register select follows IR[5] directly in every state
  assign SR2MUX = IR_5;
  assign MIO_EN = Mem_OE;

  // Next-state and control word decode; wait_d defaults to 0 so every wait
  // state is entered with a cleared counter
  always_comb begin
    state_d    = state_q;
    wait_d     = '0;
    LD_MAR     = 1'b0;
    LD_MDR     = 1'b0;
    LD_IR      = 1'b0;
    LD_BEN     = 1'b0;
    LD_CC      = 1'b0;
    LD_REG     = 1'b0;
    LD_PC      = 1'b0;
    LD_LED     = 1'b0;
    GatePC     = 1'b0;
    GateMDR    = 1'b0;
    GateALU    = 1'b0;
    GateMARMUX = 1'b0;
    PCMUX      = PC_PLUS1;
    ADDR2MUX   = A2_ZERO;
    ALUK       = ALU_ADD;
    DRMUX      = 1'b0;
    SR1MUX     = 1'b0;
    ADDR1MUX   = 1'b0;
    MARMUX     = 1'b0;
    Mem_OE     = 1'b0;
    Mem_WE     = 1'b0;

    unique case (state_q)
      StHalted: if (Run) state_d = StFetch1;
      StFetch1: begin
        GatePC  = 1'b1;
        LD_MAR  = 1'b1;
        PCMUX   = PC_PLUS1;
        LD_PC   = 1'b1;
        state_d = StFetch2;
      end
      StFetch2, StLdr2: begin
        Mem_OE = 1'b1;
        if (wait_q == WaitLast) begin
          LD_MDR  = 1'b1;
          state_d = (state_q == StFetch2) ? StFetch3 : StLdr3;
        end else begin
          wait_d = wait_q + 3'd1;
        end
      end
      StFetch3: begin
        GateMDR = 1'b1;
        LD_IR   = 1'b1;
        state_d = StDecode;
      end
      StDecode: begin
        LD_BEN = 1'b1;
        case (Opcode)
          OP_ADD:   state_d = StAdd;
          OP_AND:   state_d = StAnd;
          OP_NOT:   state_d = StNot;
          OP_BR:    state_d = StBr;
          OP_JMP:   state_d = StJmp;
          OP_JSR:   state_d = StJsr;
          OP_LDR:   state_d = StLdr1;
          OP_STR:   state_d = StStr1;
`ifdef PAUSE_EN
          OP_PAUSE: state_d = StPause1;
`endif
          default:  state_d = StFetch1;
        endcase
      end
      StAdd, StAnd, StNot: begin
        SR1MUX  = 1'b1;
        ALUK    = (state_q == StAdd) ? ALU_ADD : (state_q == StAnd) ? ALU_AND : ALU_NOT;
        GateALU = 1'b1;
        DRMUX   = 1'b0;
        LD_REG  = 1'b1;
        LD_CC   = 1'b1;
        state_d = StFetch1;
      end
      // BEN was loaded in DECODE, so it is valid here
      StBr: state_d = BEN ? StBrT : StFetch1;
      StBrT: begin
        ADDR1MUX = 1'b0;
        ADDR2MUX = A2_OFF9;
        PCMUX    = PC_ADDER;
        LD_PC    = 1'b1;
        state_d  = StFetch1;
      end
      StJmp: begin
        SR1MUX   = 1'b1;
        ADDR1MUX = 1'b1;
        ADDR2MUX = A2_ZERO;
        PCMUX    = PC_ADDER;
        LD_PC    = 1'b1;
        state_d  = StFetch1;
      end
      StJsr: begin
        GatePC  = 1'b1;
        DRMUX   = 1'b1;
        LD_REG  = 1'b1;
        state_d = StJsr2;
      end
      StJsr2: begin
        ADDR1MUX = 1'b0;
        ADDR2MUX = A2_OFF11;
        PCMUX    = PC_ADDER;
        LD_PC    = 1'b1;
        state_d  = StFetch1;
      end
      StLdr1, StStr1: begin
        SR1MUX     = 1'b1;
        ADDR1MUX   = 1'b1;
        ADDR2MUX   = A2_OFF6;
        MARMUX     = 1'b1;
        GateMARMUX = 1'b1;
        LD_MAR     = 1'b1;
        state_d    = (state_q == StLdr1) ? StLdr2 : StStr2;
      end
      StLdr3: begin
        GateMDR = 1'b1;
        DRMUX   = 1'b0;
        LD_REG  = 1'b1;
        LD_CC   = 1'b1;
        state_d = StFetch1;
      end
      // Store data passes through the ALU from SR (IR[11:9]) into MDR
      StStr2: begin
        SR1MUX  = 1'b0;
        ALUK    = ALU_PASSA;
        GateALU = 1'b1;
        LD_MDR  = 1'b1;
        state_d = StStr3;
      end
      StStr3: begin
        Mem_WE = 1'b1;
        if (wait_q == WaitLast) begin
          state_d = StFetch1;
        end else begin
          wait_d = wait_q + 3'd1;
        end
      end
`ifdef PAUSE_EN
      // Two-phase handshake: wait for Continue high, then for its release
      StPause1: begin
        LD_LED = 1'b1;
        if (Continue) state_d = StPause2;
      end
      StPause2: if (!Continue) state_d = StFetch1;
`endif
      default: state_d = StHalted;
    endcase
  end

endmodule

// File: tb/tb_isdu.sv
// Directed self-checking bench for isdu (MEM_WAIT = 3). Define PAUSE_EN for
// both bench and RTL to exercise the pause handshake.
module tb_isdu;

  logic       Clk, Reset, Run, Continue, IR_5, BEN;
  logic [3:0] Opcode;
  logic       LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
  logic       GatePC, GateMDR, GateALU, GateMARMUX;
  logic [1:0] PCMUX, ADDR2MUX, ALUK;
  logic       DRMUX, SR1MUX, SR2MUX, ADDR1MUX, MARMUX, Mem_OE, Mem_WE, MIO_EN;

  int checks = 0;
  int failures = 0;

  isdu #(.MEM_WAIT(3)) dut (
    .Clk(Clk), .Reset(Reset), .Run(Run), .Continue(Continue), .Opcode(Opcode),
    .IR_5(IR_5), .BEN(BEN),
    .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_BEN(LD_BEN), .LD_CC(LD_CC),
    .LD_REG(LD_REG), .LD_PC(LD_PC), .LD_LED(LD_LED),
    .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU), .GateMARMUX(GateMARMUX),
    .PCMUX(PCMUX), .ADDR2MUX(ADDR2MUX), .ALUK(ALUK),
    .DRMUX(DRMUX), .SR1MUX(SR1MUX), .SR2MUX(SR2MUX), .ADDR1MUX(ADDR1MUX), .MARMUX(MARMUX),
    .Mem_OE(Mem_OE), .Mem_WE(Mem_WE), .MIO_EN(MIO_EN)
  );

  // Whole control word except SR2MUX, which is checked on its own
  logic [24:0] ctl;
  assign ctl = {LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
                GatePC, GateMDR, GateALU, GateMARMUX, PCMUX, ADDR2MUX, ALUK,
                DRMUX, SR1MUX, ADDR1MUX, MARMUX, Mem_OE, Mem_WE, MIO_EN};

  localparam logic [24:0] B_LD_MAR = 25'd1 << 24;
  localparam logic [24:0] B_LD_MDR = 25'd1 << 23;
  localparam logic [24:0] B_LD_IR  = 25'd1 << 22;
  localparam logic [24:0] B_LD_BEN = 25'd1 << 21;
  localparam logic [24:0] B_LD_CC  = 25'd1 << 20;
  localparam logic [24:0] B_LD_REG = 25'd1 << 19;
  localparam logic [24:0] B_LD_PC  = 25'd1 << 18;
  localparam logic [24:0] B_LD_LED = 25'd1 << 17;
  localparam logic [24:0] B_GPC    = 25'd1 << 16;
  localparam logic [24:0] B_GMDR   = 25'd1 << 15;
  localparam logic [24:0] B_GALU   = 25'd1 << 14;
  localparam logic [24:0] B_GMARMX = 25'd1 << 13;
  localparam logic [24:0] B_PCADD  = 25'd2 << 11;
  localparam logic [24:0] B_A2OFF6 = 25'd1 << 9;
  localparam logic [24:0] B_A2OFF9 = 25'd2 << 9;
  localparam logic [24:0] B_A2OF11 = 25'd3 << 9;
  localparam logic [24:0] B_DRMUX  = 25'd1 << 6;
  localparam logic [24:0] B_SR1MUX = 25'd1 << 5;
  localparam logic [24:0] B_ADDR1  = 25'd1 << 4;
  localparam logic [24:0] B_MARMUX = 25'd1 << 3;
  localparam logic [24:0] B_OE     = 25'd1 << 2;
  localparam logic [24:0] B_WE     = 25'd1 << 1;
  localparam logic [24:0] B_MIO    = 25'd1;

  localparam logic [24:0] W_FETCH1 = B_GPC | B_LD_MAR | B_LD_PC;
  localparam logic [24:0] W_RD     = B_OE | B_MIO;
  localparam logic [24:0] W_RDLAST = B_OE | B_MIO | B_LD_MDR;
  localparam logic [24:0] W_FETCH3 = B_GMDR | B_LD_IR;
  localparam logic [24:0] W_DECODE = B_LD_BEN;
  localparam logic [24:0] W_ADRCLC = B_SR1MUX | B_ADDR1 | B_A2OFF6 | B_MARMUX | B_GMARMX | B_LD_MAR;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // At most one bus driver per cycle
  always @(negedge Clk) begin
    checks++;
    if ($countones({GatePC, GateMDR, GateALU, GateMARMUX}) > 1) begin
      failures++;
      $display("FAIL bus_gates: got %b required at most one high",
               {GatePC, GateMDR, GateALU, GateMARMUX});
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // From FETCH1 (sampled) to DECODE (sampled)
  task automatic run_fetch(input logic [3:0] op);
    Opcode = op;
    repeat (5) step();
  endtask

  task automatic test_reset();
    logic [24:0] seen;
    Reset = 1'b1; Run = 1'b0; Continue = 1'b0; Opcode = 4'b0011; IR_5 = 1'b0; BEN = 1'b0;
    #1;
    checks++;
    if (ctl !== 25'd0) begin
      failures++; $display("FAIL reset_outputs: got %h required %h", ctl, 25'd0);
    end
    step();
    Reset = 1'b0;
    seen = '0;
    repeat (3) begin
      step();
      seen = seen | ctl;
    end
    checks++;
    if (seen !== 25'd0) begin
      failures++; $display("FAIL halted_idle: got %h required %h", seen, 25'd0);
    end
  endtask

  task automatic test_fetch();
    logic [24:0] seq [$];
    Run = 1'b1;
    step();
    Run = 1'b0;
    checks++;
    if (ctl !== W_FETCH1) begin
      failures++; $display("FAIL fetch1: got %h required %h", ctl, W_FETCH1);
    end
    Opcode = 4'b0011;
    seq = '{W_RD, W_RD, W_RDLAST, W_FETCH3, W_DECODE, W_FETCH1};
    foreach (seq[i]) begin
      step();
      checks++;
      if (ctl !== seq[i]) begin
        failures++; $display("FAIL fetch_seq[%0d]: got %h required %h", i, ctl, seq[i]);
      end
    end
  endtask

  task automatic test_reset_mid_access();
    step();
    checks++;
    if (ctl !== W_RD) begin
      failures++; $display("FAIL pre_reset_fetch2: got %h required %h", ctl, W_RD);
    end
    #2 Reset = 1'b1;
    #1;
    checks++;
    if (ctl !== 25'd0) begin
      failures++; $display("FAIL reset_mid_fetch2: got %h required %h", ctl, 25'd0);
    end
    #2 Reset = 1'b0;
    Run = 1'b1;
    step();
    Run = 1'b0;
    checks++;
    if (ctl !== W_FETCH1) begin
      failures++; $display("FAIL restart_fetch1: got %h required %h", ctl, W_FETCH1);
    end
  endtask

  task automatic test_alu();
    logic [3:0]  ops  [3] = '{4'b0001, 4'b0101, 4'b1001};
    logic [24:0] aluk [3] = '{25'd0, 25'd1 << 7, 25'd2 << 7};
    logic        ir5  [3] = '{1'b1, 1'b0, 1'b1};
    logic [24:0] exp_w;
    for (int i = 0; i < 3; i++) begin
      IR_5 = ir5[i];
      run_fetch(ops[i]);
      checks++;
      if (ctl !== W_DECODE) begin
        failures++; $display("FAIL alu_decode[%0d]: got %h required %h", i, ctl, W_DECODE);
      end
      step();
      exp_w = B_SR1MUX | B_GALU | B_LD_REG | B_LD_CC | aluk[i];
      checks++;
      if (ctl !== exp_w) begin
        failures++; $display("FAIL alu_exec[%0d]: got %h required %h", i, ctl, exp_w);
      end
      checks++;
      if (SR2MUX !== ir5[i]) begin
        failures++; $display("FAIL alu_sr2mux[%0d]: got %b required %b", i, SR2MUX, ir5[i]);
      end
      step();
      checks++;
      if (ctl !== W_FETCH1) begin
        failures++; $display("FAIL alu_return[%0d]: got %h required %h", i, ctl, W_FETCH1);
      end
    end
    IR_5 = 1'b0;
  endtask

  task automatic test_branch();
    logic [24:0] seq [$];
    BEN = 1'b1;
    run_fetch(4'b0000);
    seq = '{25'd0, B_A2OFF9 | B_PCADD | B_LD_PC, W_FETCH1};
    foreach (seq[i]) begin
      step();
      checks++;
      if (ctl !== seq[i]) begin
        failures++; $display("FAIL br_taken[%0d]: got %h required %h", i, ctl, seq[i]);
      end
    end
    BEN = 1'b0;
    run_fetch(4'b0000);
    seq = '{25'd0, W_FETCH1};
    foreach (seq[i]) begin
      step();
      checks++;
      if (ctl !== seq[i]) begin
        failures++; $display("FAIL br_not_taken[%0d]: got %h required %h", i, ctl, seq[i]);
      end
    end
  endtask

  // Run held high throughout: must have no effect outside HALTED
  task automatic test_jumps();
    logic [24:0] seq [$];
    Run = 1'b1;
    run_fetch(4'b1100);
    seq = '{B_SR1MUX | B_ADDR1 | B_PCADD | B_LD_PC, W_FETCH1};
    foreach (seq[i]) begin
      step();
      checks++;
      if (ctl !== seq[i]) begin
        failures++; $display("FAIL jmp[%0d]: got %h required %h", i, ctl, seq[i]);
      end
    end
    run_fetch(4'b0100);
    seq = '{B_GPC | B_DRMUX | B_LD_REG, B_A2OF11 | B_PCADD | B_LD_PC, W_FETCH1};
    foreach (seq[i]) begin
      step();
      checks++;
      if (ctl !== seq[i]) begin
        failures++; $display("FAIL jsr[%0d]: got %h required %h", i, ctl, seq[i]);
      end
    end
    Run = 1'b0;
  endtask

  task automatic test_load();
    logic [24:0] seq [$];
    run_fetch(4'b0110);
    seq = '{W_ADRCLC, W_RD, W_RD, W_RDLAST, B_GMDR | B_LD_REG | B_LD_CC, W_FETCH1};
    foreach (seq[i]) begin
      step();
      checks++;
      if (ctl !== seq[i]) begin
        failures++; $display("FAIL ldr[%0d]: got %h required %h", i, ctl, seq[i]);
      end
    end
  endtask

  task automatic test_store();
    logic [24:0] seq [$];
    run_fetch(4'b0111);
    seq = '{W_ADRCLC, (25'd3 << 7) | B_GALU | B_LD_MDR, B_WE, B_WE, B_WE, W_FETCH1};
    foreach (seq[i]) begin
      step();
      checks++;
      if (ctl !== seq[i]) begin
        failures++; $display("FAIL str[%0d]: got %h required %h", i, ctl, seq[i]);
      end
    end
  endtask

  task automatic test_pause();
`ifdef PAUSE_EN
    logic [24:0] seq [$];
    Continue = 1'b0;
    run_fetch(4'b1101);
    seq = '{B_LD_LED, B_LD_LED, B_LD_LED};
    foreach (seq[i]) begin
      step();
      checks++;
      if (ctl !== seq[i]) begin
        failures++; $display("FAIL pause1_hold[%0d]: got %h required %h", i, ctl, seq[i]);
      end
    end
    Continue = 1'b1;
    seq = '{25'd0, 25'd0, 25'd0};
    foreach (seq[i]) begin
      step();
      checks++;
      if (ctl !== seq[i]) begin
        failures++; $display("FAIL pause2_hold[%0d]: got %h required %h", i, ctl, seq[i]);
      end
    end
    Continue = 1'b0;
    step();
    checks++;
    if (ctl !== W_FETCH1) begin
      failures++; $display("FAIL pause_exit: got %h required %h", ctl, W_FETCH1);
    end
`else
    Continue = 1'b1;
    run_fetch(4'b1101);
    step();
    checks++;
    if (ctl !== W_FETCH1) begin
      failures++; $display("FAIL pause_noop: got %h required %h", ctl, W_FETCH1);
    end
    Continue = 1'b0;
`endif
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_reset_mid_access();
    test_alu();
    test_branch();
    test_jumps();
    test_load();
    test_store();
    test_pause();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
